// File: rtl/twiddle_addr_gen_if.sv
// Bundle of start/status, ROM read port and twiddle output stream for twiddle_addr_gen.
// Latency: none (wires only).
// Backpressure: tw_valid/tw_ready on the output stream; the ROM port has no flow control.
interface twiddle_addr_gen_if #(
  parameter int N         = 32,
  parameter int word_size = 16
);
  localparam int L  = $clog2(N);
  localparam int SW = (L > 1) ? $clog2(L) : 1;
  localparam int IW = L - 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [L-1:0]             rom_read_address;
  logic [2*word_size-1:0]   rom_twiddle;
  logic                     tw_valid;
  logic                     tw_ready;
  logic [2*word_size-1:0]   twiddle;
  logic [SW-1:0]            tw_stage;
  logic [IW-1:0]            tw_index;
  logic                     tw_last;

  // Generator side
  modport master (
    input  start, rom_twiddle, tw_ready,
    output busy, done, rom_read_address, tw_valid, twiddle, tw_stage, tw_index, tw_last
  );

  // Controller / ROM / butterfly side
  modport slave (
    output start, rom_twiddle, tw_ready,
    input  busy, done, rom_read_address, tw_valid, twiddle, tw_stage, tw_index, tw_last
  );
endinterface

// File: rtl/twiddle_addr_gen.sv
// Walks every (stage, butterfly) of a radix-2 DIT FFT, reads the twiddle ROM and streams tagged twiddles.
// Latency: 2 cycles from accepted start to first tw_valid; one beat per cycle with tw_ready held high.
// Backpressure: 2-entry output buffer; issue stalls so at most one ROM read lands after tw_ready drops.
module twiddle_addr_gen #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic               clk,
  input  logic               rst,
  twiddle_addr_gen_if.master bus
);
  localparam int L  = $clog2(N);
  localparam int SW = (L > 1) ? $clog2(L) : 1;
  localparam int IW = L - 1;
  localparam int TW = 2 * word_size;

  localparam logic [SW-1:0] S_LAST = SW'(L - 1);
  localparam logic [IW-1:0] J_LAST = IW'(N / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [SW-1:0] stage;
    logic [IW-1:0] index;
    logic          last;
  } tag_t;

  typedef struct packed {
    logic [TW-1:0] twiddle;
    logic [SW-1:0] stage;
    logic [IW-1:0] index;
    logic          last;
  } beat_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [IW-1:0] j_q, j_d;
  logic [L-1:0]  addr_q, addr_d;
  logic          inflight_q, inflight_d;
  tag_t          tag_q, tag_d;
  beat_t         mem_q [2];
  beat_t         mem_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;

  logic          head_vld;
  logic          push;
  logic          pop;
  logic          issue;
  logic          at_last;
  beat_t         head;

  // ROM address of butterfly j in stage s: keep the low s bits of j, scale up to the stage stride.
  function automatic logic [L-1:0] addr_of(input logic [SW-1:0] s, input logic [IW-1:0] j);
    logic [L-1:0] mask;
    mask = (L'(1) << s) - L'(1);
    return (L'(j) & mask) << (S_LAST - s);
  endfunction

  assign head_vld = (count_q != 2'd0);
  assign pop      = head_vld && bus.tw_ready;
  assign push     = inflight_q;
  assign at_last  = (s_q == S_LAST) && (j_q == J_LAST);
  // The in-flight read is counted as already occupying a slot; a same-cycle pop frees one.
  assign issue    = (state_q == ST_RUN) && (((count_q + {1'b0, inflight_q}) < 2'd2) || pop);

  // Walk counters, registered ROM address and the tag that follows the read one cycle later.
  always_comb begin
    s_d        = s_q;
    j_d        = j_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (issue) begin
      tag_d.stage = s_q;
      tag_d.index = j_q;
      tag_d.last  = at_last;
      if (j_q == J_LAST) begin
        j_d = '0;
        s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      end else begin
        j_d = j_q + IW'(1);
      end
      addr_d = addr_of(s_d, j_d);
    end
  end

  // Two-entry output buffer; ROM data is paired with its tag as it lands.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].twiddle = bus.rom_twiddle;
      mem_d[wr_ptr_q].stage   = tag_q.stage;
      mem_d[wr_ptr_q].index   = tag_q.index;
      mem_d[wr_ptr_q].last    = tag_q.last;
      wr_ptr_d                = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pass sequencing: run until the last address goes out, then drain the read and the buffer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (issue && at_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (count_d == 2'd0)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register for FSM, counters, read pipeline and buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      j_q        <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      j_q        <= j_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head                 = mem_q[rd_ptr_q];
  assign bus.busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done             = (state_q == ST_DONE);
  assign bus.rom_read_address = addr_q;
  assign bus.tw_valid         = head_vld;
  assign bus.twiddle          = head.twiddle;
  assign bus.tw_stage         = head.stage;
  assign bus.tw_index         = head.index;
  assign bus.tw_last          = head.last;
endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Bench for twiddle_addr_gen: N=32 instance under scoreboard, N=8 instance against a fixed address table.
// Latency: checks 2-cycle start-to-valid and done one cycle after the last beat.
// Backpressure: tw_ready held high, randomized, and forced low mid-pass.
module tb_twiddle_addr_gen;
  localparam int N  = 32;
  localparam int L  = 5;

  typedef struct packed {
    logic [31:0] tw;
    logic [2:0]  st;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   rdy_mode;      // 0: ready high, 1: random, 2: ready low
  int   acc_cnt;
  int   last_acc_cyc;
  logic [3:0] last_idx;
  int   k8;
  beat_t exp_q [$];
  int   tab8 [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  twiddle_addr_gen_if #(.N(32), .word_size(16)) b32 ();
  twiddle_addr_gen_if #(.N(8),  .word_size(16)) b8 ();

  twiddle_addr_gen #(.N(32), .word_size(16)) dut32 (.clk(clk), .rst(rst), .bus(b32.master));
  twiddle_addr_gen #(.N(8),  .word_size(16)) dut8  (.clk(clk), .rst(rst), .bus(b8.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Distinct contents per address so the returned twiddle identifies the address that was read.
  function automatic logic [31:0] rom_val(input int a);
    return {16'(a * 4660 + 257), 16'(a ^ 23130)};
  endfunction

  // Registered-read ROM models.
  always @(posedge clk) b32.rom_twiddle <= rom_val(int'(b32.rom_read_address));
  always @(posedge clk) b8.rom_twiddle  <= rom_val(int'(b8.rom_read_address));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: whole pass order, stage outer, butterfly inner.
  task automatic push_pass();
    beat_t b;
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        int a;
        a      = (j % (1 << s)) * (1 << (L - 1 - s));
        b.tw   = rom_val(a);
        b.st   = 3'(s);
        b.idx  = 4'(j);
        b.last = (s == L - 1) && (j == N / 2 - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // tw_ready generator, changes just after the rising edge.
  initial begin
    b32.tw_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       b32.tw_ready = 1'b1;
        1:       b32.tw_ready = 1'($urandom_range(0, 1));
        default: b32.tw_ready = 1'b0;
      endcase
    end
  end

  // N=32 monitor: scoreboard pops on every accepted beat, stalled payload must hold.
  initial begin
    beat_t cur;
    beat_t held;
    beat_t e;
    logic  held_vld;
    held_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      cur = {b32.twiddle, b32.tw_stage, b32.tw_index, b32.tw_last};
      if (held_vld) begin
        check("hold_valid", b32.tw_valid, 1'b1);
        if (b32.tw_valid) check("hold_payload", cur, held);
      end
      held_vld = b32.tw_valid && !b32.tw_ready;
      held     = cur;
      if (b32.tw_valid && b32.tw_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        acc_cnt++;
        last_idx     = b32.tw_index;
        last_acc_cyc = cyc;
      end
    end
  end

  // N=8 monitor against the fixed address table.
  initial begin
    forever begin
      @(negedge clk);
      if (b8.tw_valid && b8.tw_ready) begin
        check("n8_in_range", k8 < 12, 1'b1);
        if (k8 < 12)
          check("n8_beat", {b8.twiddle, b8.tw_stage, b8.tw_index, b8.tw_last},
                {rom_val(tab8[k8]), 2'(k8 / 4), 2'(k8 % 4), 1'(k8 == 11)});
        k8++;
      end
    end
  end

  task automatic wait_acc(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (acc_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(nm, acc_cnt >= target, 1'b1);
  endtask

  task automatic wait_done(input int budget, input string nm, output int done_cyc);
    int n;
    n = 0;
    while (!b32.done && n < budget) begin
      tick();
      n++;
    end
    check(nm, b32.done, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic pulse_start32(output int start_cyc);
    @(posedge clk);
    #1 b32.start = 1'b1;
    @(posedge clk);
    #1 b32.start = 1'b0;
    start_cyc = cyc;
  endtask

  initial begin
    int start_cyc;
    int done_cyc;
    int lat;
    int base;
    int cnt_stall;
    int changes;
    int n;
    logic [3:0] idx_before;
    logic [4:0] addr0;

    rst          = 1'b1;
    b32.start    = 1'b0;
    b8.start     = 1'b0;
    b8.tw_ready  = 1'b1;
    rdy_mode     = 0;
    n_checks     = 0;
    n_errors     = 0;
    acc_cnt      = 0;
    k8           = 0;
    cyc          = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    tick();
    check("rst_busy", b32.busy, 1'b0);
    check("rst_done", b32.done, 1'b0);
    check("rst_valid", b32.tw_valid, 1'b0);
    check("rst_last", b32.tw_last, 1'b0);
    check("rst_addr", b32.rom_read_address, 5'd0);
    check("rst_twiddle", b32.twiddle, 32'd0);
    check("rst_stage", b32.tw_stage, 3'd0);
    check("rst_index", b32.tw_index, 4'd0);

    // Pass 1: ready high, start re-asserted mid-run
    push_pass();
    pulse_start32(start_cyc);
    tick();
    check("busy_after_start", b32.busy, 1'b1);
    lat = 1;
    while (!b32.tw_valid && lat < 10) begin
      tick();
      lat++;
    end
    // valid first visible at the falling edge after the second edge following start
    check("first_latency", lat, 3);
    wait_acc(20, 200, "p1_reach20");
    @(posedge clk);
    #1 b32.start = 1'b1;
    @(posedge clk);
    #1 b32.start = 1'b0;
    tick();
    check("busy_mid_run", b32.busy, 1'b1);
    wait_done(300, "p1_done_seen", done_cyc);
    check("p1_last_beat_edge", last_acc_cyc, start_cyc + 1 + L * N / 2);
    check("p1_done_after_last", done_cyc, last_acc_cyc + 1);
    check("p1_beat_count", acc_cnt, 80);
    check("p1_sb_empty", exp_q.size(), 0);
    check("busy_in_done", b32.busy, 1'b0);
    tick();
    check("done_pulse_width", b32.done, 1'b0);
    repeat (5) tick();
    check("no_restart", b32.tw_valid | b32.busy, 1'b0);

    // Pass 2: random ready
    rdy_mode = 1;
    base = acc_cnt;
    push_pass();
    pulse_start32(start_cyc);
    wait_done(3000, "p2_done_seen", done_cyc);
    check("p2_beat_count", acc_cnt - base, 80);
    check("p2_sb_empty", exp_q.size(), 0);
    rdy_mode = 0;
    repeat (3) tick();

    // Pass 3: ready low for 10 cycles in stage 2
    base = acc_cnt;
    push_pass();
    pulse_start32(start_cyc);
    wait_acc(base + 40, 300, "p3_reach40");
    rdy_mode   = 2;
    idx_before = last_idx;
    cnt_stall  = acc_cnt;
    tick();
    addr0   = b32.rom_read_address;
    changes = 0;
    repeat (9) begin
      tick();
      if (b32.rom_read_address != addr0) changes++;
    end
    check("stall_no_issue", changes, 0);
    check("stall_no_accept", acc_cnt, cnt_stall);
    check("stall_valid_held", b32.tw_valid, 1'b1);
    rdy_mode = 0;
    wait_acc(cnt_stall + 1, 50, "p3_resume");
    check("resume_index", last_idx, 4'(idx_before + 4'd1));
    wait_done(300, "p3_done_seen", done_cyc);
    check("p3_sb_empty", exp_q.size(), 0);
    repeat (3) tick();

    // Pass 4: reset around beat 37
    base = acc_cnt;
    push_pass();
    pulse_start32(start_cyc);
    wait_acc(base + 37, 300, "p4_reach37");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_rst_valid", b32.tw_valid, 1'b0);
    check("post_rst_busy", b32.busy, 1'b0);
    exp_q.delete();

    // Pass 5: clean restart from s=0, j=0
    base = acc_cnt;
    push_pass();
    pulse_start32(start_cyc);
    wait_done(300, "p5_done_seen", done_cyc);
    check("p5_beat_count", acc_cnt - base, 80);
    check("p5_sb_empty", exp_q.size(), 0);

    // N=8 instance
    @(posedge clk);
    #1 b8.start = 1'b1;
    @(posedge clk);
    #1 b8.start = 1'b0;
    n = 0;
    while (!b8.done && n < 100) begin
      tick();
      n++;
    end
    check("n8_done_seen", b8.done, 1'b1);
    check("n8_count", k8, 12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/twiddle_addr_gen.md
# twiddle_addr_gen

Read-side initiator for the twiddle coefficient ROM in the radix-2 DIT FFT datapath. On `start`, it walks every stage and butterfly of an N-point transform and drives the ROM read address, accounting for the ROM's 1-cycle registered read. It delivers each returned `{real, im}` twiddle to the butterfly unit over a valid/ready stream, tagged with stage and butterfly index. A 2-entry output buffer absorbs downstream stalls without losing any in-flight ROM read.

## Interface
- `N`, 32: FFT size. Power of two, ≥ 4. `L = $clog2(N)`.
- `word_size`, 16: bits per real or imaginary component.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin one full pass. Sampled only in IDLE.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.
- `rom_read_address`, output, L: registered address to the ROM.
- `rom_twiddle`, input, 2*word_size: ROM data, valid one cycle after its address.
- `tw_valid`, output, 1: output beat valid.
- `tw_ready`, input, 1: downstream accepts the beat.
- `twiddle`, output, 2*word_size: `{real, im}`, passed unmodified from the ROM.
- `tw_stage`, output, `$clog2(L)` (min 1): stage s of the beat.
- `tw_index`, output, L-1: butterfly j of the beat within its stage.
- `tw_last`, output, 1: high on the final beat (s = L-1, j = N/2-1).

## Operation
- Each pass issues L·N/2 reads. Order: s = 0..L-1 (outer), then j = 0..N/2-1 (inner).
- Address for (s, j): `(j mod 2^s) << (L-1-s)`. Always < N/2.
- State machine:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last address is issued.
  - DRAIN → DONE when nothing is in flight and the buffer is empty.
  - DONE → IDLE after one cycle.
- `done` is high only in DONE. `busy` is high in RUN and DRAIN.
- An in-flight flag marks the cycle after each issue. While it is set, `rom_twiddle` is written into the buffer with the stage/index/last tags travelling alongside.
- Issue rule, evaluated in RUN: issue when `(occupancy + inflight) < 2` or a pop occurs in the same cycle (`tw_valid && tw_ready`). This guarantees the buffer never overflows and gives full throughput of one beat per cycle when `tw_ready` is held high.
- Buffer: 2-entry FIFO. The head drives `tw_valid`, `twiddle`, `tw_stage`, `tw_index`, `tw_last`. Simultaneous push and pop is allowed, including when occupancy is 2 (the pop frees the slot).
- Payload is stable while `tw_valid && !tw_ready`.
- `start` in any state other than IDLE is ignored.
- `rst` at any point forces IDLE, clears the counters, buffer and in-flight flag, and drops any outstanding ROM read.
- Reset values: `busy`=0, `done`=0, `tw_valid`=0, `tw_last`=0, `rom_read_address`=0, `twiddle`=0, `tw_stage`=0, `tw_index`=0.

## Timing
- `start` sampled at edge E0. The first address is driven after E0 and the ROM captures it at E1. The buffer captures the data at E2, so `tw_valid` first rises after E2. Latency from `start` to the first beat is 2 cycles.
- With `tw_ready` held high, beats are contiguous:
  - last beat at edge E0 + 1 + L·N/2;
  - `done` high for the following cycle;
  - IDLE one cycle after that, when a new `start` is accepted.
- When `tw_ready` drops, at most one further ROM read lands. Issue resumes in the same cycle `tw_ready` returns.

## Test plan
- **N=32, `tw_ready`=1:** 80 beats.
  - Stage 0: 16 addresses, all 0.
  - Stage 1: 0,8,0,8,…
  - Stage 4: 0,1,…,15.
  - `tw_last` only on beat 80. `done` one cycle later. No gaps between beats.
- **Random `tw_ready` (50% duty):** the beat sequence matches a scoreboard, with no drops or duplicates. Payload is held while stalled. Occupancy never exceeds 2.
- **`tw_ready` low for 10 cycles mid-stage 2:** exactly one read lands after the stall begins. Output resumes in order, with the next beat's `tw_index` one past the last accepted.
- **`rst` pulsed at beat 37:** the next cycle shows `tw_valid`=0 and `busy`=0. A following `start` restarts at s=0, j=0.
- **`start` re-asserted during RUN:** ignored. The pass completes with exactly 80 beats.
- **N=8:** 12 beats with addresses 0,0,0,0 / 0,2,0,2 / 0,1,2,3.
